vending_machine_mp: RTL and testbench

Parametrised multi-product vending controller with credit accumulation, item selection, cancel/refund and multi-cycle change payout. It is the successor to the single-product, fixed-price vending FSM. It accepts one coin code per cycle, vends any of `N_ITEMS` products at individually parametrised prices, and returns change or refunds one coin per cycle (greedy, 10s then 5s). It sits between the coin acceptor/keypad front end and the dispenser/coin hopper drivers.

---
 rtl/vending_pkg.sv | 41 ++++
 rtl/vm_change_dispenser.sv | 35 +++
 rtl/vending_machine_mp.sv | 162 ++++++++++++++++
 tb/tb_vending_machine_mp.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/vending_pkg.sv
`default_nettype none
// ============================================================================
// Module : vending_pkg
// Brief  : Shared coin/change codes, coin valuation and controller state type
//          for the multi-product vending controller.
// Rev    : 1.0  initial release
// ============================================================================
package vending_pkg;

  // Coin acceptor codes
  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN_5    = 2'b01;
  localparam logic [1:0] COIN_10   = 2'b10;
  localparam logic [1:0] COIN_20   = 2'b11;

  // Hopper change codes
  localparam logic [1:0] CHANGE_NONE = 2'b00;
  localparam logic [1:0] CHANGE_5    = 2'b01;
  localparam logic [1:0] CHANGE_10   = 2'b10;

  // Controller states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_VEND   = 2'd1,
    ST_PAYOUT = 2'd2
  } vm_state_t;

  // Monetary value of a coin code (0 for "no coin")
  function automatic logic [4:0] coin_value(input logic [1:0] code);
    logic [4:0] v;
    case (code)
      COIN_5:  v = 5'd5;
      COIN_10: v = 5'd10;
      COIN_20: v = 5'd20;
      default: v = 5'd0;
    endcase
    return v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/vm_change_dispenser.sv
`default_nettype none
// ============================================================================
// Module : vm_change_dispenser
// Brief  : Greedy single-coin change step: picks a 10 when possible, else a 5,
//          and returns the credit left after that coin.
// Rev    : 1.0  initial release
// ============================================================================
module vm_change_dispenser
  import vending_pkg::*;
#(
  parameter int CREDIT_W = 8
) (
  input  logic [CREDIT_W-1:0] credit,
  output logic [1:0]          change_code,
  output logic [CREDIT_W-1:0] credit_next
);

  localparam logic [CREDIT_W-1:0] c_ten  = CREDIT_W'(10);
  localparam logic [CREDIT_W-1:0] c_five = CREDIT_W'(5);

  // Credit is always a multiple of 5, so a nonzero value below 10 is exactly 5
  always_comb begin
    change_code = CHANGE_NONE;
    credit_next = credit;
    if (credit >= c_ten) begin
      change_code = CHANGE_10;
      credit_next = credit - c_ten;
    end else if (credit != '0) begin
      change_code = CHANGE_5;
      credit_next = credit - c_five;
    end
  end

endmodule
`default_nettype wire

// File: rtl/vending_machine_mp.sv
`default_nettype none
// ============================================================================
// Module : vending_machine_mp
// Brief  : Multi-product vending controller: credit accumulation with
//          saturation reject, item selection, cancel/refund and a greedy
//          one-coin-per-cycle change payout.
// Rev    : 1.0  initial release
// ============================================================================
module vending_machine_mp
  import vending_pkg::*;
#(
  parameter int                          N_ITEMS     = 4,
  parameter int                          CREDIT_W    = 8,
  parameter int                          MAX_CREDIT  = 50,
  parameter logic [N_ITEMS*CREDIT_W-1:0] ITEM_PRICES = {8'd30, 8'd25, 8'd20, 8'd15},
  parameter int                          SEL_W       = $clog2(N_ITEMS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          in,
  input  logic                sel_valid,
  input  logic [SEL_W-1:0]    sel,
  input  logic                cancel,
  output logic                out,
  output logic [SEL_W-1:0]    item,
  output logic [1:0]          change,
  output logic [CREDIT_W-1:0] credit,
  output logic                busy,
  output logic                coin_reject,
  output logic                insufficient
);

  localparam logic [CREDIT_W:0] c_max_ext = (CREDIT_W+1)'(MAX_CREDIT);

  vm_state_t           r_state;
  logic [CREDIT_W-1:0] r_credit;
  logic [SEL_W-1:0]    r_item;
  logic                r_out;
  logic [1:0]          r_change;
  logic                r_busy;
  logic                r_coin_reject;
  logic                r_insufficient;

  logic [CREDIT_W-1:0] w_price;
  logic                w_sel_ok;
  logic                w_short;
  logic                w_coin_present;
  logic [CREDIT_W:0]   w_sum;
  logic                w_fits;
  logic [1:0]          w_chg_code;
  logic [CREDIT_W-1:0] w_chg_credit;
  int unsigned         w_sel_idx;

  // Price lookup for the requested item; out-of-range indices read as 0
  always_comb begin
    w_price = '0;
    for (int i = 0; i < N_ITEMS; i++) begin
      if (sel == SEL_W'(i)) w_price = ITEM_PRICES[i*CREDIT_W +: CREDIT_W];
    end
  end

  // Select validity, credit shortfall and coin-fit checks (one spare bit on the sum)
  always_comb begin
    w_sel_idx      = 32'(sel);
    w_sel_ok       = (w_sel_idx < N_ITEMS);
    w_short        = (r_credit < w_price);
    w_coin_present = (in != COIN_NONE);
    w_sum          = {1'b0, r_credit} + {{(CREDIT_W-4){1'b0}}, coin_value(in)};
    w_fits         = (w_sum <= c_max_ext);
  end

  vm_change_dispenser #(
    .CREDIT_W (CREDIT_W)
  ) u_change (
    .credit      (r_credit),
    .change_code (w_chg_code),
    .credit_next (w_chg_credit)
  );

  // Controller FSM with all outputs registered; strobes default low every cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= ST_IDLE;
      r_credit       <= '0;
      r_item         <= '0;
      r_out          <= 1'b0;
      r_change       <= CHANGE_NONE;
      r_busy         <= 1'b0;
      r_coin_reject  <= 1'b0;
      r_insufficient <= 1'b0;
    end else begin
      r_out          <= 1'b0;
      r_change       <= CHANGE_NONE;
      r_coin_reject  <= 1'b0;
      r_insufficient <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_busy <= 1'b0;
          if (cancel && (r_credit != '0)) begin
            // Refund: first coin leaves on this edge
            r_change      <= w_chg_code;
            r_credit      <= w_chg_credit;
            r_state       <= ST_PAYOUT;
            r_busy        <= 1'b1;
            r_coin_reject <= w_coin_present;
          end else if (sel_valid && w_sel_ok && !w_short) begin
            r_item        <= sel;
            r_out         <= 1'b1;
            r_credit      <= r_credit - w_price;
            r_state       <= ST_VEND;
            r_busy        <= 1'b1;
            r_coin_reject <= w_coin_present;
          end else begin
            // A refused select is not an action, so a coin in that cycle is still taken
            if (sel_valid) r_insufficient <= 1'b1;
            if (w_coin_present) begin
              if (w_fits) r_credit <= w_sum[CREDIT_W-1:0];
              else        r_coin_reject <= 1'b1;
            end
          end
        end
        ST_VEND: begin
          r_coin_reject <= w_coin_present;
          if (r_credit != '0) begin
            r_change <= w_chg_code;
            r_credit <= w_chg_credit;
            r_state  <= ST_PAYOUT;
            r_busy   <= 1'b1;
          end else begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        end
        ST_PAYOUT: begin
          r_coin_reject <= w_coin_present;
          if (r_credit != '0) begin
            r_change <= w_chg_code;
            r_credit <= w_chg_credit;
            r_busy   <= 1'b1;
          end else begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign out          = r_out;
  assign item         = r_item;
  assign change       = r_change;
  assign credit       = r_credit;
  assign busy         = r_busy;
  assign coin_reject  = r_coin_reject;
  assign insufficient = r_insufficient;

endmodule
`default_nettype wire

// File: tb/tb_vending_machine_mp.sv
`default_nettype none
// ============================================================================
// Module : tb_vending_machine_mp
// Brief  : Directed self-checking bench for vending_machine_mp. A second
//          three-item instance shares the stimulus to exercise an index
//          that is out of range.
// Rev    : 1.0  initial release
// ============================================================================
module tb_vending_machine_mp;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] in = 2'b00;
  logic       sel_valid = 1'b0;
  logic [1:0] sel = 2'b00;
  logic       cancel = 1'b0;

  logic       out, busy, coin_reject, insufficient;
  logic [1:0] item, change;
  logic [7:0] credit;

  logic       b_out, b_busy, b_coin_reject, b_insufficient;
  logic [1:0] b_item, b_change;
  logic [7:0] b_credit;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  vending_machine_mp dut (
    .clk (clk), .rst (rst), .in (in), .sel_valid (sel_valid), .sel (sel),
    .cancel (cancel), .out (out), .item (item), .change (change),
    .credit (credit), .busy (busy), .coin_reject (coin_reject),
    .insufficient (insufficient)
  );

  vending_machine_mp #(
    .N_ITEMS (3), .CREDIT_W (8), .MAX_CREDIT (50),
    .ITEM_PRICES ({8'd25, 8'd20, 8'd15}), .SEL_W (2)
  ) dut3 (
    .clk (clk), .rst (rst), .in (in), .sel_valid (sel_valid), .sel (sel),
    .cancel (cancel), .out (b_out), .item (b_item), .change (b_change),
    .credit (b_credit), .busy (b_busy), .coin_reject (b_coin_reject),
    .insufficient (b_insufficient)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs, then land 1 time unit after the edge
  task automatic drive(input logic [1:0] c, input logic sv, input logic [1:0] s, input logic cn);
    in = c; sel_valid = sv; sel = s; cancel = cn;
    @(posedge clk); #1;
    in = 2'b00; sel_valid = 1'b0; sel = 2'b00; cancel = 1'b0;
  endtask

  task automatic idle();
    drive(2'b00, 1'b0, 2'b00, 1'b0);
  endtask

  initial begin
    // Reset
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_credit", credit, 0);
    chk("rst_out", out, 0);
    chk("rst_change", change, 0);
    chk("rst_busy", busy, 0);
    chk("rst_reject", coin_reject, 0);
    chk("rst_insuff", insufficient, 0);
    chk("rst_item", item, 0);
    rst = 1'b0;

    // Buy item 0 (15) with 10+10, 5 change
    drive(2'b10, 0, 0, 0);  chk("buy_c1", credit, 10);
    drive(2'b10, 0, 0, 0);  chk("buy_c2", credit, 20);
    drive(2'b00, 1, 0, 0);
    chk("buy_out", out, 1); chk("buy_item", item, 0);
    chk("buy_credit", credit, 5); chk("buy_busy", busy, 1);
    idle();
    chk("buy_out_off", out, 0); chk("buy_chg", change, 1);
    chk("buy_credit0", credit, 0); chk("buy_busy2", busy, 1);
    idle();
    chk("buy_chg_end", change, 0); chk("buy_idle", busy, 0);

    // Insufficient credit: 20 against item 3 (30)
    drive(2'b11, 0, 0, 0);  chk("ins_c", credit, 20);
    drive(2'b00, 1, 3, 0);
    chk("ins_pulse", insufficient, 1); chk("ins_out", out, 0);
    chk("ins_credit", credit, 20); chk("ins_busy", busy, 0);
    idle();
    chk("ins_pulse_off", insufficient, 0);

    // Refund of 35 -> 10,10,10,5
    drive(2'b10, 0, 0, 0);  chk("ref_c1", credit, 30);
    drive(2'b01, 0, 0, 0);  chk("ref_c2", credit, 35);
    drive(2'b00, 0, 0, 1);
    chk("ref_chg1", change, 2); chk("ref_busy1", busy, 1); chk("ref_cr1", credit, 25);
    idle();
    chk("ref_chg2", change, 2); chk("ref_busy2", busy, 1); chk("ref_cr2", credit, 15);
    idle();
    chk("ref_chg3", change, 2); chk("ref_busy3", busy, 1); chk("ref_cr3", credit, 5);
    idle();
    chk("ref_chg4", change, 1); chk("ref_busy4", busy, 1); chk("ref_cr4", credit, 0);
    idle();
    chk("ref_chg5", change, 0); chk("ref_busy5", busy, 0);

    // Saturation at MAX_CREDIT and coin rejected while paying out
    drive(2'b11, 0, 0, 0);
    drive(2'b11, 0, 0, 0);  chk("sat_c40", credit, 40);
    drive(2'b11, 0, 0, 0);
    chk("sat_reject", coin_reject, 1); chk("sat_hold", credit, 40);
    drive(2'b10, 0, 0, 0);
    chk("sat_c50", credit, 50); chk("sat_reject_off", coin_reject, 0);
    drive(2'b00, 0, 0, 1);  chk("pay_cr40", credit, 40);
    drive(2'b01, 0, 0, 0);
    chk("pay_reject", coin_reject, 1); chk("pay_cr30", credit, 30); chk("pay_chg", change, 2);

    // Reset during payout with credit 30
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid_rst_chg", change, 0); chk("mid_rst_cr", credit, 0);
    chk("mid_rst_busy", busy, 0); chk("mid_rst_rej", coin_reject, 0);
    idle();
    chk("mid_rst_stay", change, 0);

    // Normal purchase afterwards: item 1 (20), exact credit
    drive(2'b11, 0, 0, 0);  chk("post_c", credit, 20);
    drive(2'b00, 1, 1, 0);
    chk("post_out", out, 1); chk("post_item", item, 1); chk("post_cr", credit, 0);
    idle();
    chk("post_out_off", out, 0); chk("post_busy", busy, 0); chk("post_chg", change, 0);

    // Priority: cancel + select + coin with credit 25
    drive(2'b11, 0, 0, 0);
    drive(2'b01, 0, 0, 0);  chk("pri_c25", credit, 25);
    drive(2'b10, 1, 0, 1);
    chk("pri_out", out, 0); chk("pri_reject", coin_reject, 1);
    chk("pri_chg", change, 2); chk("pri_cr", credit, 15); chk("pri_busy", busy, 1);
    idle();
    chk("pri_chg2", change, 2); chk("pri_cr2", credit, 5); chk("pri_rej_off", coin_reject, 0);
    idle();
    chk("pri_chg3", change, 1); chk("pri_cr3", credit, 0);
    idle();
    chk("pri_done", busy, 0);

    // Index 3 is valid for the 4-item DUT but out of range for the 3-item one
    drive(2'b11, 0, 0, 0);
    drive(2'b10, 0, 0, 0);
    chk("inv_c", credit, 30); chk("inv_c_b", b_credit, 30);
    drive(2'b00, 1, 3, 0);
    chk("inv_b_insuff", b_insufficient, 1); chk("inv_b_out", b_out, 0);
    chk("inv_b_cr", b_credit, 30); chk("inv_b_busy", b_busy, 0);
    chk("inv_a_out", out, 1); chk("inv_a_item", item, 3);
    chk("inv_a_cr", credit, 0); chk("inv_a_insuff", insufficient, 0);
    idle();
    chk("inv_a_idle", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
